// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared widths, coordinate types and default 1280x800 raster timing
//
// Package contents:
//   X_W, Y_W        coordinate widths (columns up to 2048, lines up to 1024)
//   pix_x_t/pix_y_t coordinate types
//   *_DEF           default 1280x800 timing, used as parameter defaults by vga_timing_gen
package vga_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef logic [X_W-1:0] pix_x_t;
    typedef logic [Y_W-1:0] pix_y_t;

    localparam int H_ACTIVE_DEF = 1280;
    localparam int H_FP_DEF     = 64;
    localparam int H_SYNC_DEF   = 136;
    localparam int H_BP_DEF     = 200;
    localparam int V_ACTIVE_DEF = 800;
    localparam int V_FP_DEF     = 1;
    localparam int V_SYNC_DEF   = 3;
    localparam int V_BP_DEF     = 24;

    localparam logic HSYNC_POL_DEF = 1'b0;
    localparam logic VSYNC_POL_DEF = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping position counter with active/sync flags
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   inc         advance the position by one (wrapping at TOTAL-1)
//   count       registered position, resets to TOTAL-1
//   wrap        combinational: this inc moves count from TOTAL-1 to 0
//   active      combinational: the position being loaded is < ACTIVE
//   sync        combinational: the position being loaded is in [SYNC_START, SYNC_END)
//
// active/sync describe the next count value so the parent can register them on the
// same edge as count, keeping flags and coordinate aligned.
module vga_axis_counter #(
    parameter int W          = 11,
    parameter int TOTAL      = 1680,
    parameter int ACTIVE     = 1280,
    parameter int SYNC_START = 1344,
    parameter int SYNC_END   = 1480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         active,
    output logic         sync
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT  = W'(ACTIVE);
    localparam logic [W-1:0] SS   = W'(SYNC_START);
    localparam logic [W-1:0] SE   = W'(SYNC_END);

    logic [W-1:0] count_nxt;

    always_comb begin
        wrap = inc && (count == LAST);
        if (!inc) begin
            count_nxt = count;
        end else if (count == LAST) begin
            count_nxt = '0;
        end else begin
            count_nxt = count + 1'b1;
        end
        active = (count_nxt < ACT);
        sync   = (count_nxt >= SS) && (count_nxt < SE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else begin
            count <= count_nxt;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator, one pixel per pix_en
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pix_en           pixel strobe; raster advances one position per clk with pix_en=1
//   pix_x_out        current column 0..H_TOTAL-1
//   pix_y_out        current line 0..V_TOTAL-1
//   in_screen_out    coordinate is inside the visible area
//   hsync_out        horizontal sync pin level (HSYNC_POL while asserted)
//   vsync_out        vertical sync pin level (VSYNC_POL while asserted)
//   line_start_out   one-clk pulse on the strobe that moves x to 0
//   frame_start_out  one-clk pulse on the strobe that moves the raster to (0,0)
//   frame_cnt_out    frame counter, present only with VGA_TIMING_FRAME_CNT_EN defined
//
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_DEF,
    parameter int   H_FP      = H_FP_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BP      = H_BP_DEF,
    parameter int   V_ACTIVE  = V_ACTIVE_DEF,
    parameter int   V_FP      = V_FP_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BP      = V_BP_DEF,
    parameter logic HSYNC_POL = HSYNC_POL_DEF,
    parameter logic VSYNC_POL = VSYNC_POL_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    output logic [X_W-1:0] pix_x_out,
    output logic [Y_W-1:0] pix_y_out,
    output logic           in_screen_out,
    output logic           hsync_out,
    output logic           vsync_out,
    output logic           line_start_out,
    output logic           frame_start_out
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]    frame_cnt_out
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 2048 || V_TOTAL > 1024 ||
        H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_err
        $error("vga_timing_gen: illegal timing parameters");
    end

    logic h_wrap, h_active, h_sync;
    logic v_wrap, v_active, v_sync;

    vga_axis_counter #(
        .W          (X_W),
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (pix_en),
        .count  (pix_x_out),
        .wrap   (h_wrap),
        .active (h_active),
        .sync   (h_sync)
    );

    // The vertical axis steps only on the strobe that ends a line.
    vga_axis_counter #(
        .W          (Y_W),
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (h_wrap),
        .count  (pix_y_out),
        .wrap   (v_wrap),
        .active (v_active),
        .sync   (v_sync)
    );

    // Flags are taken from the counters' next-state view, so registering them here
    // lines them up with the coordinate registers on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_screen_out   <= 1'b0;
            hsync_out       <= ~HSYNC_POL;
            vsync_out       <= ~VSYNC_POL;
            line_start_out  <= 1'b0;
            frame_start_out <= 1'b0;
        end else begin
            in_screen_out   <= h_active & v_active;
            hsync_out       <= h_sync ? HSYNC_POL : ~HSYNC_POL;
            vsync_out       <= v_sync ? VSYNC_POL : ~VSYNC_POL;
            line_start_out  <= h_wrap;
            frame_start_out <= h_wrap & v_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_out <= 16'h0000;
        end else if (h_wrap && v_wrap) begin
            frame_cnt_out <= frame_cnt_out + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    localparam int   S_HA = 8, S_HFP = 2, S_HS = 2, S_HBP = 2;
    localparam int   S_VA = 4, S_VFP = 1, S_VS = 1, S_VBP = 1;
    localparam int   HT = S_HA + S_HFP + S_HS + S_HBP;
    localparam int   VT = S_VA + S_VFP + S_VS + S_VBP;
    localparam int   FR = HT * VT;
    localparam logic HPOL = 1'b0;
    localparam logic VPOL = 1'b1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst_n, s_en, s_ins, s_hs, s_vs, s_ls, s_fs;
    logic [10:0] s_x;
    logic [9:0]  s_y;
    logic        d_rst_n, d_en, d_ins, d_hs, d_vs, d_ls, d_fs;
    logic [10:0] d_x;
    logic [9:0]  d_y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] s_fc, d_fc;
`endif

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .pix_en(s_en),
        .pix_x_out(s_x), .pix_y_out(s_y), .in_screen_out(s_ins),
        .hsync_out(s_hs), .vsync_out(s_vs),
        .line_start_out(s_ls), .frame_start_out(s_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt_out(s_fc)
`endif
    );

    vga_timing_gen u_dflt (
        .clk(clk), .rst_n(d_rst_n), .pix_en(d_en),
        .pix_x_out(d_x), .pix_y_out(d_y), .in_screen_out(d_ins),
        .hsync_out(d_hs), .vsync_out(d_vs),
        .line_start_out(d_ls), .frame_start_out(d_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt_out(d_fc)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the raster is a single position index into the frame.
    int   m_pos;
    logic m_ls, m_fs;
    int   m_fc;

    task automatic model_reset();
        m_pos = FR - 1;
        m_ls  = 1'b0;
        m_fs  = 1'b0;
        m_fc  = 0;
    endtask

    task automatic step(input logic en);
        s_en = en;
        @(posedge clk);
        #1;
        if (en) begin
            m_pos = (m_pos + 1) % FR;
            m_ls  = (m_pos % HT) == 0;
            m_fs  = (m_pos == 0);
            if (m_fs) m_fc = (m_fc + 1) % 65536;
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
    endtask

    task automatic chk_model(input string tag);
        int   x, y;
        logic e_ins, e_hs, e_vs;
        x     = m_pos % HT;
        y     = m_pos / HT;
        e_ins = (x < S_HA) && (y < S_VA);
        e_hs  = (x >= S_HA + S_HFP && x < S_HA + S_HFP + S_HS) ? HPOL : ~HPOL;
        e_vs  = (y >= S_VA + S_VFP && y < S_VA + S_VFP + S_VS) ? VPOL : ~VPOL;
        chk({tag, ".x"}, 32'(s_x), x);
        chk({tag, ".y"}, 32'(s_y), y);
        chk({tag, ".in_screen"}, 32'(s_ins), 32'(e_ins));
        chk({tag, ".hsync"}, 32'(s_hs), 32'(e_hs));
        chk({tag, ".vsync"}, 32'(s_vs), 32'(e_vs));
        chk({tag, ".line_start"}, 32'(s_ls), 32'(m_ls));
        chk({tag, ".frame_start"}, 32'(s_fs), 32'(m_fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, ".frame_cnt"}, 32'(s_fc), m_fc);
`endif
    endtask

    task automatic chk_lit(input string tag, input int x, input int y, input logic ins,
                           input logic hs, input logic vs, input logic ls, input logic fs);
        chk({tag, ".x"}, 32'(s_x), x);
        chk({tag, ".y"}, 32'(s_y), y);
        chk({tag, ".in_screen"}, 32'(s_ins), 32'(ins));
        chk({tag, ".hsync"}, 32'(s_hs), 32'(hs));
        chk({tag, ".vsync"}, 32'(s_vs), 32'(vs));
        chk({tag, ".line_start"}, 32'(s_ls), 32'(ls));
        chk({tag, ".frame_start"}, 32'(s_fs), 32'(fs));
    endtask

    typedef struct {
        logic en;
        int   x;
        int   y;
        logic ins;
        logic hs;
        logic vs;
        logic ls;
        logic fs;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, nfs, hs_low, ins_cnt, ls_at;

        //            en    x   y  ins  hs   vs   ls   fs
        tbl.push_back('{1'b0, 13, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{1'b0,  0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  2, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  3, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  4, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  5, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  6, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  7, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  8, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  9, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 10, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 11, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 12, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 13, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{1'b1,  0, 1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0});

        s_rst_n = 1'b0;
        d_rst_n = 1'b0;
        s_en    = 1'b0;
        d_en    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;

        chk_lit("reset", 13, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("d_reset.x", 32'(d_x), 1679);
        chk("d_reset.y", 32'(d_y), 827);
        chk("d_reset.hsync", 32'(d_hs), 1);
        chk("d_reset.vsync", 32'(d_vs), 0);
        chk("d_reset.in_screen", 32'(d_ins), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("reset.frame_cnt", 32'(s_fc), 0);
`endif

        s_rst_n = 1'b1;
        foreach (tbl[i]) begin
            step(tbl[i].en);
            chk_lit($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].ins,
                    tbl[i].hs, tbl[i].vs, tbl[i].ls, tbl[i].fs);
        end

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)));
            chk_model("rand");
        end

        // Full-rate frame period.
        for (int k = 0; k < 2 * FR && !s_fs; k++) step(1'b1);
        chk("align_full.frame_start", 32'(s_fs), 1);
        cnt = 0;
        do begin
            step(1'b1);
            chk_model("full");
            cnt++;
        end while (!s_fs && cnt < 2 * FR);
        chk("frame_period_full", cnt, FR);

        // Strobe every 4th clk.
        cnt = 0;
        do begin
            cnt++;
            step(1'((cnt % 4) == 0));
            chk_model("quarter");
        end while (!s_fs && cnt < 8 * FR);
        chk("frame_period_quarter", cnt, 4 * FR);

        // Frame wrap from (13,6) and line wrap from (13,2).
        for (int k = 0; k < FR && m_pos != 13 + 6 * HT; k++) step(1'b1);
        chk_lit("at_13_6", 13, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        chk_lit("wrap_frame", 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < FR && m_pos != 13 + 2 * HT; k++) step(1'b1);
        chk_lit("at_13_2", 13, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1);
        chk_lit("wrap_line", 0, 3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-clock at (5,2).
        for (int k = 0; k < FR && m_pos != 5 + 2 * HT; k++) step(1'b1);
        chk_lit("at_5_2", 5, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #3;
        s_rst_n = 1'b0;
        #1;
        chk_lit("async_reset", 13, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("async_reset.frame_cnt", 32'(s_fc), 0);
`endif
        model_reset();
        @(posedge clk);
        #1;
        chk_lit("reset_held", 13, 6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        s_rst_n = 1'b1;
        step(1'b1);
        chk_lit("restart", 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk_model("restart");

        // Third frame start after reset.
        nfs = 1;
        for (int k = 0; k < 4 * FR && nfs < 3; k++) begin
            step(1'b1);
            chk_model("frames");
            if (s_fs) nfs++;
        end
        chk("third_frame_seen", nfs, 3);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_cnt_third", 32'(s_fc), 3);
`endif
        s_en = 1'b0;

        // Default 1280x800 timing: one full line at pixel rate = clk.
        d_rst_n = 1'b1;
        d_en    = 1'b1;
        @(posedge clk);
        #1;
        chk("d_first.x", 32'(d_x), 0);
        chk("d_first.y", 32'(d_y), 0);
        chk("d_first.frame_start", 32'(d_fs), 1);
        chk("d_first.line_start", 32'(d_ls), 1);
        hs_low  = 0;
        ins_cnt = 0;
        ls_at   = 0;
        for (int c = 1; c <= 2000 && ls_at == 0; c++) begin
            if (!d_hs) hs_low++;
            if (d_ins) ins_cnt++;
            @(posedge clk);
            #1;
            if (d_ls) ls_at = c;
        end
        chk("d_line_period", ls_at, 1680);
        chk("d_hsync_low_clks", hs_low, 136);
        chk("d_in_screen_clks", ins_cnt, 1280);
        chk("d_line1.y", 32'(d_y), 1);
        chk("d_line1.frame_start", 32'(d_fs), 0);
        d_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator; the stage directly upstream of every box/sprite renderer.
- Produces the current pixel coordinate (pix_x_out, pix_y_out), the active-region flag (in_screen_out), and the hsync/vsync pins.
- Advances one pixel per pix_en strobe, so one system clock serves any pixel rate.
- Renderers consume the coordinate combinationally; the top level registers the final RGB alongside the delayed syncs.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 64, horizontal front porch (pixels)
- H_SYNC, 136, hsync pulse width (pixels)
- H_BP, 200, horizontal back porch (pixels)
- V_ACTIVE, 800, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vsync pulse width (lines)
- V_BP, 24, vertical back porch (lines)
- HSYNC_POL, 1'b0, hsync level while asserted (0 = active-low)
- VSYNC_POL, 1'b1, vsync level while asserted

Ports:
- clk  input  1  system clock; one clock, all logic on the rising edge
- rst_n  input  1  asynchronous, active-low reset
- pix_en  input  1  pixel strobe; the raster advances one position per clk with pix_en=1
- pix_x_out  output  11  current column, 0..H_TOTAL-1
- pix_y_out  output  10  current line, 0..V_TOTAL-1
- in_screen_out  output  1  1 iff pix_x_out<H_ACTIVE and pix_y_out<V_ACTIVE
- hsync_out  output  1  horizontal sync pin level
- vsync_out  output  1  vertical sync pin level
- line_start_out  output  1  one-clk pulse on the pix_en cycle that moves pix_x_out to 0
- frame_start_out  output  1  one-clk pulse on the pix_en cycle that moves the raster to (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, and V_TOTAL is defined the same way.
- Elaboration-time checks: H_TOTAL ≤ 2048, V_TOTAL ≤ 1024, every parameter ≥ 1.
- All outputs are registered.
  - in_screen_out, hsync_out and vsync_out always describe the coordinate currently on pix_x_out/pix_y_out, with zero skew between them.
  - The implementation therefore derives these flags from the next-state counter values.
- Reset (rst_n=0, asynchronous):
  - pix_x_out=H_TOTAL-1, pix_y_out=V_TOTAL-1, in_screen_out=0.
  - hsync_out=~HSYNC_POL, vsync_out=~VSYNC_POL.
  - line_start_out=0, frame_start_out=0.
- Advance, on a clk with pix_en=1:
  - x = (x==H_TOTAL-1) ? 0 : x+1.
  - When x wraps, y = (y==V_TOTAL-1) ? 0 : y+1.
- Hold: pix_en=0 leaves all outputs unchanged, except the pulses, which drop to 0.
- First strobe after reset therefore lands on (0,0) with frame_start_out=1 and line_start_out=1.
- Sync windows:
  - hsync asserted iff H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted iff V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC.
  - vsync depends on y only and changes on line boundaries.
- Pulses:
  - line_start_out is 1 for exactly one clk per line.
  - frame_start_out coincides with a line_start_out, once per frame.
- Reset mid-frame returns immediately to the reset state. There is no partial-frame completion.
- pix_en held at 1 every clk is legal (pixel rate = clk).

Optional Feature:
- Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined:
  - Adds output frame_cnt_out [15:0], reset 0.
  - Increments on every frame_start_out pulse and wraps 16'hFFFF→0.
  - The first frame after reset reports 1.
  - Used by animation and blink logic.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package vga_pkg holds:
  - coordinate widths (X_W=11, Y_W=10)
  - typedefs pix_x_t and pix_y_t
  - the default 1280x800 timing constants, which are the parameter defaults here
- One natural sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical).
  - Parameters: TOTAL, SYNC_START, SYNC_END, ACTIVE.
  - Inputs: an increment enable.
  - Outputs: count, wrap, active flag, sync-window flag.

Test Plan:
- Small timing (H 8/2/2/2 → H_TOTAL 14; V 4/1/1/1 → V_TOTAL 7), pix_en=1:
  - After reset release, the first clk gives (0,0) with frame_start=1, line_start=1, in_screen=1.
  - frame_start recurs every 98 clks.
- Same config, x scan:
  - in_screen is 1 for x 0..7 on y 0..3 and 0 elsewhere.
  - hsync equals HSYNC_POL exactly at x=10,11.
  - vsync equals VSYNC_POL exactly for all x on y=5.
- pix_en pulsed every 4th clk:
  - Coordinates advance once per strobe and hold in between.
  - Pulses last exactly 1 clk.
  - Frame period is 392 clks.
- Wrap: at (13,6) with pix_en=1 → (0,0) and frame_start=1. At (13,2) → (0,3) with line_start=1 and frame_start=0.
- Assert rst_n=0 asynchronously at (5,2), mid-clk:
  - Outputs go to the reset values without waiting for a clock edge.
  - After release, the sequence restarts at (0,0).
- Default 1280x800 with VGA_TIMING_FRAME_CNT_EN defined:
  - 1680×828 clks per frame.
  - frame_cnt_out reads 3 after the third frame_start.
  - hsync is low for exactly 136 clks per line.
